// File: rtl/jesd204b_pkg.sv
// Shared JESD204B receive-side types and constants.
package jesd204b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        CS_INIT  = 2'd0,
        CS_CHECK = 2'd1,
        CS_DATA  = 2'd2
    } cs_state_t;

    // Width of a counter that must be able to hold the value tgt.
    function automatic int unsigned cnt_w(input int unsigned tgt);
        return $clog2(tgt + 1);
    endfunction

endpackage

// File: rtl/rx_char_qual.sv
// Combinational classifier: flags a decoded character as a valid /K/ or as invalid.
module rx_char_qual
    import jesd204b_pkg::*;
(
    input  logic       i_vld,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_disp_err,
    input  logic       i_nit_err,
    output logic       o_valid_k,
    output logic       o_invalid
);

    assign o_invalid = i_vld & (i_disp_err | i_nit_err);
    assign o_valid_k = i_vld & ~(i_disp_err | i_nit_err) & i_k & (i_data == K28_5);

endmodule

// File: rtl/rx_cgs_sync.sv
// JESD204B receive code group synchronization FSM: drives SYNC~ and qualifies data-phase characters.
module rx_cgs_sync
    import jesd204b_pkg::*;
#(
    parameter int unsigned K_CNT_TGT   = 4,
    parameter int unsigned ERR_TGT     = 3,
    parameter int unsigned GOOD_RUN    = 4,
    parameter int unsigned MIN_LOW_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_vld,
    input  logic       i_disp_err,
    input  logic       i_nit_err,
    input  logic       i_lmfc,
    output logic       o_sync_n,
    output logic [1:0] o_cs_state,
    output logic       o_cgs_done,
    output logic       o_err_pulse,
    output logic [7:0] o_data,
    output logic       o_k,
    output logic       o_vld
);

    localparam int unsigned KW = cnt_w(K_CNT_TGT);
    localparam int unsigned EW = cnt_w(ERR_TGT);
    localparam int unsigned GW = cnt_w(GOOD_RUN);
    localparam int unsigned LW = cnt_w(MIN_LOW_CYC);

    cs_state_t   state_q, state_d;
    logic [KW-1:0] k_cnt_q, k_cnt_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic        sync_n_q, sync_n_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  data_q;
    logic        k_q, vld_q, vld_d;
    logic        valid_k, invalid;

    rx_char_qual u_qual (
        .i_vld      (i_vld),
        .i_data     (i_data),
        .i_k        (i_k),
        .i_disp_err (i_disp_err),
        .i_nit_err  (i_nit_err),
        .o_valid_k  (valid_k),
        .o_invalid  (invalid)
    );

    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        err_cnt_d   = err_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_pulse_d = 1'b0;
        if (sync_n_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q == LW'(MIN_LOW_CYC)) begin
            low_cnt_d = low_cnt_q;
        end else begin
            low_cnt_d = low_cnt_q + 1'b1;
        end

        unique case (state_q)
            CS_INIT: begin
                if (valid_k) begin
                    if (k_cnt_q == KW'(K_CNT_TGT - 1)) begin
                        state_d = CS_CHECK;
                        k_cnt_d = '0;
                    end else begin
                        k_cnt_d = k_cnt_q + 1'b1;
                    end
                end else if (i_vld) begin
                    k_cnt_d = '0;
                end
            end
            CS_CHECK: begin
                // A bad character outranks a coincident LMFC release.
                if (invalid) begin
                    state_d = CS_INIT;
                end else if (i_lmfc && low_cnt_q == LW'(MIN_LOW_CYC)) begin
                    state_d = CS_DATA;
                end
            end
            CS_DATA: begin
                if (invalid) begin
                    err_pulse_d = 1'b1;
                    good_cnt_d  = '0;
                    if (err_cnt_q == EW'(ERR_TGT - 1)) begin
                        state_d   = CS_INIT;
                        err_cnt_d = '0;
                        low_cnt_d = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else if (i_vld) begin
                    if (good_cnt_q == GW'(GOOD_RUN - 1)) begin
                        good_cnt_d = '0;
                        if (err_cnt_q != '0) begin
                            err_cnt_d = err_cnt_q - 1'b1;
                        end
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = CS_INIT;
        endcase

        sync_n_d = (state_d == CS_DATA);
        vld_d    = i_vld & (state_q == CS_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CS_INIT;
            k_cnt_q     <= '0;
            err_cnt_q   <= '0;
            good_cnt_q  <= '0;
            low_cnt_q   <= '0;
            sync_n_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            data_q      <= '0;
            k_q         <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            err_cnt_q   <= err_cnt_d;
            good_cnt_q  <= good_cnt_d;
            low_cnt_q   <= low_cnt_d;
            sync_n_q    <= sync_n_d;
            err_pulse_q <= err_pulse_d;
            data_q      <= i_data;
            k_q         <= i_k;
            vld_q       <= vld_d;
        end
    end

    assign o_sync_n    = sync_n_q;
    assign o_cs_state  = state_q;
    assign o_cgs_done  = (state_q == CS_DATA);
    assign o_err_pulse = err_pulse_q;
    assign o_data      = data_q;
    assign o_k         = k_q;
    assign o_vld       = vld_q;

endmodule

// File: tb/tb_rx_cgs_sync.sv
// Directed, table-driven bench for the receive CGS synchronizer.
module tb_rx_cgs_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_k = 1'b0, i_vld = 1'b0, i_disp_err = 1'b0, i_nit_err = 1'b0, i_lmfc = 1'b0;
    logic       o_sync_n, o_cgs_done, o_err_pulse, o_k, o_vld;
    logic [1:0] o_cs_state;
    logic [7:0] o_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         rep;
        logic       vld;
        logic [7:0] data;
        logic       k, de, ne, lmfc;
        logic [1:0] st;
        logic       sn, ep, ov;
    } vec_t;

    vec_t vt[$];

    rx_cgs_sync dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_k         (i_k),
        .i_vld       (i_vld),
        .i_disp_err  (i_disp_err),
        .i_nit_err   (i_nit_err),
        .i_lmfc      (i_lmfc),
        .o_sync_n    (o_sync_n),
        .o_cs_state  (o_cs_state),
        .o_cgs_done  (o_cgs_done),
        .o_err_pulse (o_err_pulse),
        .o_data      (o_data),
        .o_k         (o_k),
        .o_vld       (o_vld)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int rep, input logic vld, input logic [7:0] data,
                                input logic k, input logic de, input logic ne, input logic lmfc,
                                input logic [1:0] st, input logic sn, input logic ep,
                                input logic ov);
        vec_t v;
        v.rep = rep; v.vld = vld; v.data = data; v.k = k; v.de = de; v.ne = ne; v.lmfc = lmfc;
        v.st = st; v.sn = sn; v.ep = ep; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [7:0] data, input logic k,
                         input logic de, input logic ne, input logic lmfc);
        i_vld = vld; i_data = data; i_k = k; i_disp_err = de; i_nit_err = ne; i_lmfc = lmfc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic sn,
                              input logic ep, input logic ov);
        chk($sformatf("%s state", tag), {6'd0, o_cs_state}, {6'd0, st});
        chk($sformatf("%s sync_n", tag), {7'd0, o_sync_n}, {7'd0, sn});
        chk($sformatf("%s cgs_done", tag), {7'd0, o_cgs_done}, {7'd0, (st == 2'd2)});
        chk($sformatf("%s err_pulse", tag), {7'd0, o_err_pulse}, {7'd0, ep});
        chk($sformatf("%s vld", tag), {7'd0, o_vld}, {7'd0, ov});
    endtask

    task automatic expect_reset(input string tag);
        expect_out(tag, 2'd0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("%s data", tag), o_data, 8'h00);
        chk($sformatf("%s k", tag), {7'd0, o_k}, 8'h00);
    endtask

    initial begin
        // Reset, 4 /K/, release on LMFC, then data-phase error accounting.
        vt.push_back(mk(3, 1, 8'hBC, 1, 0, 0, 0, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 1, 8'hBC, 1, 0, 0, 0, 2'd1, 0, 0, 0));
        vt.push_back(mk(11, 0, 8'h00, 0, 0, 0, 0, 2'd1, 0, 0, 0));
        vt.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 2'd2, 1, 0, 0));
        vt.push_back(mk(1, 1, 8'h5A, 0, 0, 0, 0, 2'd2, 1, 0, 1));
        vt.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 2'd2, 1, 1, 1));
        vt.push_back(mk(4, 1, 8'h33, 0, 0, 0, 0, 2'd2, 1, 0, 1));
        vt.push_back(mk(1, 1, 8'h5A, 0, 1, 0, 0, 2'd2, 1, 1, 1));
        vt.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 2'd2, 1, 0, 0));
        vt.push_back(mk(4, 1, 8'h33, 0, 0, 0, 0, 2'd2, 1, 0, 1));
        vt.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 2'd2, 1, 1, 1));
        vt.push_back(mk(1, 1, 8'hBC, 1, 0, 0, 0, 2'd2, 1, 0, 1));
        vt.push_back(mk(3, 1, 8'h33, 0, 0, 0, 0, 2'd2, 1, 0, 1));
        // Three errors separated by two good chars force resync.
        vt.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 2'd2, 1, 1, 1));
        vt.push_back(mk(2, 1, 8'h33, 0, 0, 0, 0, 2'd2, 1, 0, 1));
        vt.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 2'd2, 1, 1, 1));
        vt.push_back(mk(2, 1, 8'h33, 0, 0, 0, 0, 2'd2, 1, 0, 1));
        vt.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 2'd0, 0, 1, 1));
        vt.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 0));

        i_data = 8'hFF;
        i_k    = 1'b1;
        i_vld  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_reset("por");
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            for (int r = 0; r < vt[i].rep; r++) begin
                drive(vt[i].vld, vt[i].data, vt[i].k, vt[i].de, vt[i].ne, vt[i].lmfc);
                expect_out($sformatf("vec%0d.%0d", i, r), vt[i].st, vt[i].sn, vt[i].ep,
                           vt[i].ov);
                chk($sformatf("vec%0d.%0d data", i, r), o_data, vt[i].data);
                chk($sformatf("vec%0d.%0d k", i, r), {7'd0, o_k}, {7'd0, vt[i].k});
            end
        end

        // k_cnt restarts on a non-/K/ char and holds across an idle cycle.
        repeat (3) begin
            drive(1, 8'hBC, 1, 0, 0, 0);
            expect_out("krun", 2'd0, 0, 0, 0);
        end
        drive(1, 8'h1C, 0, 0, 0, 0);
        expect_out("kbreak", 2'd0, 0, 0, 0);
        repeat (2) begin
            drive(1, 8'hBC, 1, 0, 0, 0);
            expect_out("krestart", 2'd0, 0, 0, 0);
        end
        drive(0, 8'h00, 0, 0, 0, 0);
        expect_out("khold", 2'd0, 0, 0, 0);
        drive(1, 8'hBC, 1, 0, 0, 0);
        expect_out("k3", 2'd0, 0, 0, 0);
        drive(1, 8'hBC, 1, 0, 0, 0);
        expect_out("k4", 2'd1, 0, 0, 0);

        // Invalid char together with LMFC in CS_CHECK: back to INIT.
        drive(1, 8'hBC, 1, 1, 0, 1);
        expect_out("chk_inv_lmfc", 2'd0, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0, 0);
        expect_out("chk_inv_after", 2'd0, 0, 0, 0);

        // Fresh reset so the SYNC~ low time is short on CS_CHECK entry.
        rst_n = 1'b0;
        #1;
        expect_reset("rst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            drive(1, 8'hBC, 1, 0, 0, 0);
            expect_out("t6k", 2'd0, 0, 0, 0);
        end
        drive(1, 8'hBC, 1, 0, 0, 0);
        expect_out("t6enter", 2'd1, 0, 0, 0);
        repeat (3) begin
            drive(0, 8'h00, 0, 0, 0, 0);
            expect_out("t6wait", 2'd1, 0, 0, 0);
        end
        drive(0, 8'h00, 0, 0, 0, 1);
        expect_out("t6lmfc_short", 2'd1, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0, 1);
        expect_out("t6lmfc_ok", 2'd2, 1, 0, 0);

        // Asynchronous reset in the middle of CS_DATA.
        drive(1, 8'hA5, 0, 0, 1, 0);
        expect_out("pre_rst", 2'd2, 1, 1, 1);
        chk("pre_rst data", o_data, 8'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("mid_rst");
        @(posedge clk);
        #1;
        expect_reset("mid_rst_hold");
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
